fp_accum_sequencer: RTL and testbench

- Sequential controller between the 32x32 floating-point register file and the single-precision combinational fp adder.
- On a start pulse it reads COUNT consecutive register-file entries and sums them through the adder.
- It writes the IEEE-754 single-precision sum back to a destination register and reports completion with a done pulse and the result.

---
 rtl/fp_accum_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_fp_accum_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_accum_sequencer.sv
// ---------------------------------------------------------------------------
// fp_accum_sequencer
//
// Sums `count` consecutive register-file entries through an external
// combinational single-precision adder and writes the sum back to a
// destination register.
//
// Ports
//   clk              rising-edge clock
//   reset            asynchronous, active-low reset
//   start            one-cycle request, only looked at while idle
//   src_base         address of the first operand
//   count            number of operands, 0..2^ADDR_W
//   dst_addr         destination register for the sum (captured at start)
//   busy             high from the cycle after an accepted start until done
//   done             one-cycle completion pulse
//   err              count was zero, or the sum exponent is all ones
//   result           final sum, held until the next accepted start
//   rf_write_enable  register-file write strobe
//   rf_mode          register-file mode: 0 = write, 1 = read
//   rf_addr          register-file address
//   rf_wdata         register-file write data
//   rf_rdata         register-file read data, valid one cycle after rf_addr
//   fp_a, fp_b       adder operands (accumulator, operand register)
//   fp_sum           adder result
// ---------------------------------------------------------------------------
module fp_accum_sequencer #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W:0]   count,
    input  logic [ADDR_W-1:0] dst_addr,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] result,
    output logic              rf_write_enable,
    output logic              rf_mode,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic [DATA_W-1:0] fp_a,
    output logic [DATA_W-1:0] fp_b,
    input  logic [DATA_W-1:0] fp_sum
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_LATCH,
        S_ACCUM,
        S_WRITE,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W:0]     rem_q, rem_d;
    logic                first_q, first_d;
    logic [ADDR_W-1:0]   dst_q, dst_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [DATA_W-1:0]   operand_q, operand_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                rf_we_q, rf_we_d;
    logic                rf_mode_q, rf_mode_d;
    logic [ADDR_W-1:0]   rf_addr_q, rf_addr_d;
    logic [DATA_W-1:0]   rf_wdata_q, rf_wdata_d;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        rem_d      = rem_q;
        first_d    = first_q;
        dst_d      = dst_q;
        acc_d      = acc_q;
        operand_d  = operand_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = err_q;
        result_d   = result_q;
        rf_we_d    = 1'b0;
        rf_mode_d  = 1'b1;
        rf_addr_d  = rf_addr_q;
        rf_wdata_d = rf_wdata_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    busy_d = 1'b1;
                    if (count != '0) begin
                        ptr_d     = src_base;
                        rem_d     = count;
                        first_d   = 1'b1;
                        dst_d     = dst_addr;
                        err_d     = 1'b0;
                        // Address is registered on entry so it is already
                        // on the bus for the whole READ cycle.
                        rf_addr_d = src_base;
                        state_d   = S_READ;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_READ: begin
                state_d = S_LATCH;
            end
            S_LATCH: begin
                operand_d = rf_rdata;
                state_d   = S_ACCUM;
            end
            S_ACCUM: begin
                // The first operand seeds the accumulator instead of being
                // added to a zero, so a lone -0.0 or NaN passes through intact.
                acc_d   = first_q ? operand_q : fp_sum;
                first_d = 1'b0;
                ptr_d   = ptr_q + 1'b1;
                rem_d   = rem_q - 1'b1;
                if (rem_q == {{ADDR_W{1'b0}}, 1'b1}) begin
                    // Write strobe is registered on entry to WRITE and the
                    // defaults drop it again one cycle later.
                    rf_we_d    = 1'b1;
                    rf_mode_d  = 1'b0;
                    rf_addr_d  = dst_q;
                    rf_wdata_d = acc_d;
                    state_d    = S_WRITE;
                end else begin
                    rf_addr_d = ptr_q + 1'b1;
                    state_d   = S_READ;
                end
            end
            S_WRITE: begin
                result_d = acc_q;
                if (acc_q[DATA_W-2 -: 8] == 8'hFF) begin
                    err_d = 1'b1;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            rem_q      <= '0;
            first_q    <= 1'b0;
            dst_q      <= '0;
            acc_q      <= '0;
            operand_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            result_q   <= '0;
            rf_we_q    <= 1'b0;
            rf_mode_q  <= 1'b1;
            rf_addr_q  <= '0;
            rf_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            rem_q      <= rem_d;
            first_q    <= first_d;
            dst_q      <= dst_d;
            acc_q      <= acc_d;
            operand_q  <= operand_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            result_q   <= result_d;
            rf_we_q    <= rf_we_d;
            rf_mode_q  <= rf_mode_d;
            rf_addr_q  <= rf_addr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign err             = err_q;
    assign result          = result_q;
    assign rf_write_enable = rf_we_q;
    assign rf_mode         = rf_mode_q;
    assign rf_addr         = rf_addr_q;
    assign rf_wdata        = rf_wdata_q;
    assign fp_a            = acc_q;
    assign fp_b            = operand_q;

endmodule

// File: tb/tb_fp_accum_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fp_accum_sequencer
//
// Surrounds the sequencer with a 32-entry register file and a behavioural
// single-precision adder. Directed vectors come from a table; a random phase
// compares each run against a fold of the adder over the source entries.
// ---------------------------------------------------------------------------
module tb_fp_accum_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [4:0]  src_base;
    logic [5:0]  count;
    logic [4:0]  dst_addr;
    logic        busy, done, err;
    logic [31:0] result;
    logic        rf_write_enable, rf_mode;
    logic [4:0]  rf_addr;
    logic [31:0] rf_wdata, rf_rdata;
    logic [31:0] fp_a, fp_b, fp_sum;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    fp_accum_sequencer dut (
        .clk             (clk),
        .reset           (rst_n),
        .start           (start),
        .src_base        (src_base),
        .count           (count),
        .dst_addr        (dst_addr),
        .busy            (busy),
        .done            (done),
        .err             (err),
        .result          (result),
        .rf_write_enable (rf_write_enable),
        .rf_mode         (rf_mode),
        .rf_addr         (rf_addr),
        .rf_wdata        (rf_wdata),
        .rf_rdata        (rf_rdata),
        .fp_a            (fp_a),
        .fp_b            (fp_b),
        .fp_sum          (fp_sum)
    );

    // Behavioural adder: truncating, denormals flushed to zero.
    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] big, sml;
        logic [24:0] mb, ms, m;
        int          eb, es, e;
        if (a[30:23] == 8'h00) return b;
        if (b[30:23] == 8'h00) return a;
        if (a[30:0] >= b[30:0]) begin big = a; sml = b; end
        else begin big = b; sml = a; end
        eb = int'(big[30:23]);
        es = int'(sml[30:23]);
        mb = {2'b01, big[22:0]};
        ms = {2'b01, sml[22:0]};
        ms = (eb - es > 24) ? 25'd0 : (ms >> (eb - es));
        e  = eb;
        m  = (big[31] == sml[31]) ? (mb + ms) : (mb - ms);
        if (m == 25'd0) return 32'h0;
        if (m[24]) begin m = m >> 1; e++; end
        while (!m[23]) begin m = m << 1; e--; end
        if (e >= 255) return {big[31], 8'hFF, 23'h0};
        if (e <= 0) return 32'h0;
        return {big[31], 8'(e), m[22:0]};
    endfunction

    assign fp_sum = fp_add(fp_a, fp_b);

    // Register file with a backdoor port for preloading from the bench.
    logic [31:0] rf_mem [32];
    logic        bd_we = 1'b0;
    logic [4:0]  bd_addr = '0;
    logic [31:0] bd_data = '0;
    int          wr_cnt = 0;

    always @(posedge clk) begin
        if (bd_we) rf_mem[bd_addr] <= bd_data;
        else if (rf_write_enable && !rf_mode) rf_mem[rf_addr] <= rf_wdata;
        if (rf_mode) rf_rdata <= rf_mem[rf_addr];
        if (rf_write_enable) wr_cnt <= wr_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [4:0] a, input logic [31:0] v);
        @(negedge clk);
        bd_we = 1'b1; bd_addr = a; bd_data = v;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, " busy"},   32'(busy), 32'd0);
        chk({tag, " done"},   32'(done), 32'd0);
        chk({tag, " err"},    32'(err), 32'd0);
        chk({tag, " result"}, result, 32'h0);
        chk({tag, " rf_we"},  32'(rf_write_enable), 32'd0);
        chk({tag, " rf_mode"}, 32'(rf_mode), 32'd1);
        chk({tag, " rf_addr"}, 32'(rf_addr), 32'd0);
        chk({tag, " rf_wdata"}, rf_wdata, 32'h0);
        chk({tag, " fp_a"}, fp_a, 32'h0);
        chk({tag, " fp_b"}, fp_b, 32'h0);
    endtask

    // Runs one operation. Latency is the index of the edge (start edge = 0)
    // that begins the done cycle. inject >= 0 raises a stray start while busy.
    task automatic run_op(input logic [4:0] src, input logic [5:0] cnt, input logic [4:0] dst,
                          input logic [31:0] exp_res, input logic exp_err, input int exp_lat,
                          input int inject, input string tag);
        int lat;
        int w0;
        lat = -1;
        @(negedge clk);
        start = 1'b1; src_base = src; count = cnt; dst_addr = dst;
        w0 = wr_cnt;
        @(posedge clk);
        #1;
        start = 1'b0;
        src_base = 5'($urandom); count = 6'($urandom); dst_addr = 5'($urandom);
        for (int k = 0; k < 120; k++) begin
            @(negedge clk);
            if (k == 0) chk({tag, " busy"}, 32'(busy), 32'd1);
            start = (k == inject) ? 1'b1 : 1'b0;
            if (done) begin
                lat = k;
                break;
            end
        end
        start = 1'b0;
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " result"}, result, exp_res);
        chk({tag, " err"}, 32'(err), 32'(exp_err));
        chk({tag, " writes"}, 32'(wr_cnt - w0), (cnt != 6'd0) ? 32'd1 : 32'd0);
        if (cnt != 6'd0) chk({tag, " dst"}, rf_mem[dst], exp_res);
        @(negedge clk);
        chk({tag, " done width"}, 32'(done), 32'd0);
        if (inject >= 0) begin
            repeat (3) @(negedge clk);
            chk({tag, " no queued op"}, {30'd0, busy, done}, 32'd0);
        end
    endtask

    function automatic logic [31:0] model_sum(input logic [4:0] src, input logic [5:0] cnt);
        logic [31:0] acc;
        acc = rf_mem[src];
        for (int i = 1; i < int'(cnt); i++) acc = fp_add(acc, rf_mem[5'(int'(src) + i)]);
        return acc;
    endfunction

    function automatic logic [31:0] rand_fp();
        return {1'($urandom), 8'($urandom_range(120, 134)), 23'($urandom)};
    endfunction

    typedef struct {
        logic [4:0]  src;
        logic [5:0]  cnt;
        logic [4:0]  dst;
        int          npre;
        logic [4:0]  pa0;
        logic [31:0] pv0;
        logic [4:0]  pa1;
        logic [31:0] pv1;
        logic [31:0] res;
        logic        err;
        int          lat;
        int          inject;
    } vec_t;

    vec_t tbl[6];

    initial begin
        logic [31:0] last_res;
        logic [31:0] exp_v;
        logic [4:0]  s, d;
        logic [5:0]  c;
        int          w0;

        tbl[0] = '{5'd1,  6'd3, 5'd10, 0, 5'd0,  32'h0,        5'd0, 32'h0,        32'h40C00000, 1'b0, 11, 4};
        tbl[1] = '{5'd5,  6'd1, 5'd6,  1, 5'd5,  32'hC1200000, 5'd0, 32'h0,        32'hC1200000, 1'b0, 5, -1};
        tbl[2] = '{5'd31, 6'd2, 5'd7,  2, 5'd31, 32'h3F800000, 5'd0, 32'h3F800000, 32'h40000000, 1'b0, 8, -1};
        tbl[3] = '{5'd4,  6'd2, 5'd8,  2, 5'd4,  32'h7F7FFFFF, 5'd5, 32'h7F7FFFFF, 32'h7F800000, 1'b1, 8, -1};
        tbl[4] = '{5'd0,  6'd0, 5'd9,  0, 5'd0,  32'h0,        5'd0, 32'h0,        32'h7F800000, 1'b1, 1, -1};
        tbl[5] = '{5'd1,  6'd3, 5'd11, 0, 5'd0,  32'h0,        5'd0, 32'h0,        32'h40C00000, 1'b0, 11, -1};

        rst_n = 1'b0; start = 1'b0; src_base = '0; count = '0; dst_addr = '0;
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 32; i++) preload(5'(i), 32'h0);
        preload(5'd1, 32'h3F800000);
        preload(5'd2, 32'h40000000);
        preload(5'd3, 32'h40400000);

        for (int i = 0; i < 6; i++) begin
            if (tbl[i].npre > 0) preload(tbl[i].pa0, tbl[i].pv0);
            if (tbl[i].npre > 1) preload(tbl[i].pa1, tbl[i].pv1);
            run_op(tbl[i].src, tbl[i].cnt, tbl[i].dst, tbl[i].res, tbl[i].err,
                   tbl[i].lat, tbl[i].inject, $sformatf("vec%0d", i));
        end

        // Abort a 4-operand run while it is latching the first operand.
        preload(5'd4, 32'h40800000);
        preload(5'd12, 32'hDEADBEEF);
        @(negedge clk);
        start = 1'b1; src_base = 5'd1; count = 6'd4; dst_addr = 5'd12;
        w0 = wr_cnt;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_vals("abort");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("abort dst untouched", rf_mem[12], 32'hDEADBEEF);
        chk("abort writes", 32'(wr_cnt - w0), 32'd0);
        run_op(5'd1, 6'd4, 5'd12, 32'h41200000, 1'b0, 14, -1, "after abort");
        last_res = 32'h41200000;

        // Random phase against the fold-over-entries model.
        for (int i = 0; i < 32; i++) preload(5'(i), rand_fp());
        for (int t = 0; t < 20; t++) begin
            preload(5'($urandom), rand_fp());
            s = 5'($urandom);
            d = 5'($urandom);
            c = (t % 7 == 3) ? 6'd0 : 6'($urandom_range(1, 32));
            if (c == 6'd0) begin
                run_op(s, c, d, last_res, 1'b1, 1, -1, $sformatf("rand%0d", t));
            end else begin
                exp_v = model_sum(s, c);
                run_op(s, c, d, exp_v, (exp_v[30:23] == 8'hFF), 3 * int'(c) + 2, -1,
                       $sformatf("rand%0d", t));
                last_res = exp_v;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
